// File: rtl/iic_cmd_sequencer.sv
// Host-side command sequencer in front of the I2C master engine: buffers write
// bytes, launches one transaction at a time and reports its outcome.
module iic_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_rw,
    input  logic [6:0] i_cmd_address,
    input  logic [7:0] i_cmd_len,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [7:0] i_wr_byte,
    output logic       o_rd_valid,
    output logic [7:0] o_rd_byte,
    output logic       o_busy,
    output logic       o_txn_done,
    output logic [1:0] o_error,
    output logic       o_m_start,
    output logic       o_m_rw,
    output logic [6:0] o_m_address,
    output logic [7:0] o_m_amount_of_bytes,
    output logic [7:0] o_m_w_byte,
    output logic       o_m_abort,
    input  logic       i_m_busy,
    input  logic       i_m_byte_req,
    input  logic       i_m_r_valid,
    input  logic [7:0] i_m_r_byte,
    input  logic       i_m_nack,
    input  logic       i_m_done
);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  FULL    = CW'(FIFO_DEPTH);
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit             WD_EN   = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, WAIT_STOP, DONE} state_t;

    state_t         state_q;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     remaining_q;
    logic [WDW-1:0] wd_q;
    logic           wr_ready_q, cmd_ready_q, busy_q, rd_valid_q, txn_done_q;
    logic           m_start_q, m_abort_q, m_rw_q;
    logic [7:0]     rd_byte_q, m_len_q;
    logic [6:0]     m_addr_q;
    logic [1:0]     error_q;
    logic           push, pop, flush, byte_evt, underrun, m_event, wd_hit;

    always_comb begin
        push     = i_wr_valid && wr_ready_q;
        byte_evt = (state_q == RUN) && (remaining_q != 8'd0) &&
                   (m_rw_q ? i_m_r_valid : i_m_byte_req);
        flush    = (state_q == RUN) && i_m_nack;
        underrun = byte_evt && !m_rw_q && (count_q == '0);
        pop      = byte_evt && !m_rw_q && (count_q != '0) && !flush;
        m_event  = i_m_byte_req || i_m_r_valid || i_m_nack || i_m_done;
        // wd_q counts earlier idle cycles, so a hit marks the last allowed one
        wd_hit   = WD_EN && !m_event && (wd_q == WD_LAST);
        count_d  = count_q;
        if (flush)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= 8'd0;
            wd_q        <= '0;
            wr_ready_q  <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            txn_done_q  <= 1'b0;
            m_start_q   <= 1'b0;
            m_abort_q   <= 1'b0;
            m_rw_q      <= 1'b0;
            rd_byte_q   <= 8'd0;
            m_len_q     <= 8'd0;
            m_addr_q    <= 7'd0;
            error_q     <= 2'b00;
        end else begin
            rd_valid_q <= 1'b0;
            txn_done_q <= 1'b0;
            m_start_q  <= 1'b0;
            m_abort_q  <= 1'b0;
            count_q    <= count_d;
            wr_ready_q <= (count_d != FULL);
            wd_q       <= m_event ? '0 : wd_q + WDW'(1);

            // a flush discards everything, including a push in the same cycle
            if (push && !flush) begin
                mem_q[wr_ptr_q] <= i_wr_byte;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (flush)
                rd_ptr_q <= wr_ptr_q;
            else if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);

            if (byte_evt) remaining_q <= remaining_q - 8'd1;
            if (byte_evt && m_rw_q) begin
                rd_byte_q  <= i_m_r_byte;
                rd_valid_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    wd_q <= '0;
                    if (i_cmd_valid && cmd_ready_q && (i_cmd_rw || count_q != '0)) begin
                        m_rw_q      <= i_cmd_rw;
                        m_addr_q    <= i_cmd_address;
                        m_len_q     <= (i_cmd_len == 8'd0) ? 8'd1 : i_cmd_len;
                        remaining_q <= (i_cmd_len == 8'd0) ? 8'd1 : i_cmd_len;
                        error_q     <= 2'b00;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wd_q <= '0;
                    if (!i_m_busy) begin
                        m_start_q <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (i_m_nack) begin
                        error_q <= 2'b01;
                        wd_q    <= '0;
                        state_q <= i_m_done ? DONE : WAIT_STOP;
                    end else if (underrun) begin
                        error_q <= 2'b10;
                        wd_q    <= '0;
                        if (i_m_done) begin
                            state_q <= DONE;
                        end else begin
                            m_abort_q <= 1'b1;
                            state_q   <= WAIT_STOP;
                        end
                    end else if (i_m_done) begin
                        state_q <= DONE;
                    end else if (wd_hit) begin
                        error_q   <= 2'b11;
                        m_abort_q <= 1'b1;
                        wd_q      <= '0;
                        state_q   <= WAIT_STOP;
                    end
                end
                WAIT_STOP: begin
                    if (i_m_done || wd_hit) state_q <= DONE;
                end
                DONE: begin
                    txn_done_q  <= 1'b1;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_cmd_ready         = cmd_ready_q;
    assign o_wr_ready          = wr_ready_q;
    assign o_rd_valid          = rd_valid_q;
    assign o_rd_byte           = rd_byte_q;
    assign o_busy              = busy_q;
    assign o_txn_done          = txn_done_q;
    assign o_error             = error_q;
    assign o_m_start           = m_start_q;
    assign o_m_rw              = m_rw_q;
    assign o_m_address         = m_addr_q;
    assign o_m_amount_of_bytes = m_len_q;
    assign o_m_w_byte          = mem_q[rd_ptr_q];
    assign o_m_abort           = m_abort_q;

endmodule

// File: tb/tb_iic_cmd_sequencer.sv
// Directed and randomized bench for iic_cmd_sequencer against a queue-based model.
module tb_iic_cmd_sequencer;
    localparam int DEPTH = 16;
    localparam int TMO   = 20;

    logic       i_clk = 1'b0, i_rst = 1'b1;
    logic       i_cmd_valid = 1'b0, i_cmd_rw = 1'b0;
    logic [6:0] i_cmd_address = 7'd0;
    logic [7:0] i_cmd_len = 8'd0;
    logic       i_wr_valid = 1'b0;
    logic [7:0] i_wr_byte = 8'd0;
    logic       i_m_busy = 1'b0, i_m_byte_req = 1'b0, i_m_r_valid = 1'b0;
    logic [7:0] i_m_r_byte = 8'd0;
    logic       i_m_nack = 1'b0, i_m_done = 1'b0;
    logic       o_cmd_ready, o_wr_ready, o_rd_valid, o_busy, o_txn_done;
    logic       o_m_start, o_m_rw, o_m_abort;
    logic [7:0] o_rd_byte, o_m_amount_of_bytes, o_m_w_byte;
    logic [6:0] o_m_address;
    logic [1:0] o_error;

    iic_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_rw(i_cmd_rw),
        .i_cmd_address(i_cmd_address), .i_cmd_len(i_cmd_len),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_byte(i_wr_byte),
        .o_rd_valid(o_rd_valid), .o_rd_byte(o_rd_byte), .o_busy(o_busy),
        .o_txn_done(o_txn_done), .o_error(o_error),
        .o_m_start(o_m_start), .o_m_rw(o_m_rw), .o_m_address(o_m_address),
        .o_m_amount_of_bytes(o_m_amount_of_bytes), .o_m_w_byte(o_m_w_byte),
        .o_m_abort(o_m_abort), .i_m_busy(i_m_busy), .i_m_byte_req(i_m_byte_req),
        .i_m_r_valid(i_m_r_valid), .i_m_r_byte(i_m_r_byte), .i_m_nack(i_m_nack),
        .i_m_done(i_m_done)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0, checks = 0, cyc = 0;
    int n_start = 0, n_abort = 0, n_done = 0, t_start = 0, t_abort = 0, t_done = 0;
    logic [7:0] fifo_m[$];
    logic [7:0] rd_got[$];
    logic [7:0] rd_exp[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock; outputs are sampled on the falling edge
    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
        if (o_m_start)  begin n_start++; t_start = cyc; end
        if (o_m_abort)  begin n_abort++; t_abort = cyc; end
        if (o_txn_done) begin n_done++;  t_done  = cyc; end
        if (o_rd_valid) rd_got.push_back(o_rd_byte);
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) tick();
    endtask

    task automatic push(input logic [7:0] v);
        bool_push: begin
            bit room;
            room = (fifo_m.size() < DEPTH);
            chk("wr_ready", o_wr_ready, room);
            i_wr_valid = 1'b1; i_wr_byte = v;
            tick();
            i_wr_valid = 1'b0;
            if (room) fifo_m.push_back(v);
        end
    endtask

    task automatic send_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] len);
        int i;
        i = 0;
        while (!o_cmd_ready && i < 50) begin tick(); i++; end
        i_cmd_valid = 1'b1; i_cmd_rw = rw; i_cmd_address = addr; i_cmd_len = len;
        tick();
        i_cmd_valid = 1'b0;
        chk("accept_busy", o_busy, 1);
        chk("accept_ready", o_cmd_ready, 0);
    endtask

    task automatic wait_start(input int s0);
        int i;
        i = 0;
        while (n_start == s0 && i < 20) begin tick(); i++; end
        chk("start_seen", n_start - s0, 1);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int i;
        i = 0;
        while (n_done == d0 && i < budget) begin tick(); i++; end
        chk("done_seen", n_done - d0, 1);
    endtask

    task automatic pulse_done();
        i_m_done = 1'b1; tick(); i_m_done = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] len, input bit merge);
        int L, s0, d0, a0;
        bit under, merged;
        L = (len == 8'd0) ? 1 : int'(len);
        s0 = n_start; d0 = n_done; a0 = n_abort; under = 0; merged = 0;
        send_cmd(1'b0, addr, len);
        wait_start(s0);
        chk("w_m_rw", o_m_rw, 0);
        chk("w_m_addr", o_m_address, addr);
        chk("w_m_len", o_m_amount_of_bytes, L);
        for (int i = 0; i < L && !under; i++) begin
            gap();
            if (fifo_m.size() == 0) begin
                under = 1;
                i_m_byte_req = 1'b1; tick(); i_m_byte_req = 1'b0;
                chk("underrun_abort", n_abort - a0, 1);
                chk("underrun_err", o_error, 2'b10);
            end else begin
                chk("w_byte", o_m_w_byte, fifo_m[0]);
                merged = merge && (i == L - 1);
                i_m_byte_req = 1'b1; i_m_done = merged;
                tick();
                i_m_byte_req = 1'b0; i_m_done = 1'b0;
                void'(fifo_m.pop_front());
            end
        end
        if (!merged) begin gap(); pulse_done(); end
        wait_done(d0, 8);
        chk("w_err", o_error, under ? 2'b10 : 2'b00);
        chk("w_starts", n_start - s0, 1);
        if (!under) chk("w_no_abort", n_abort - a0, 0);
        chk("w_idle", o_busy, 0);
    endtask

    task automatic do_read(input logic [6:0] addr, input logic [7:0] len, input bit extra,
                           input bit fixed);
        int L, s0, d0;
        logic [7:0] v;
        L = (len == 8'd0) ? 1 : int'(len);
        s0 = n_start; d0 = n_done;
        rd_got.delete(); rd_exp.delete();
        send_cmd(1'b1, addr, len);
        wait_start(s0);
        chk("r_m_rw", o_m_rw, 1);
        chk("r_m_addr", o_m_address, addr);
        chk("r_m_len", o_m_amount_of_bytes, L);
        for (int i = 0; i < L; i++) begin
            gap();
            v = fixed ? ((i == 0) ? 8'h5A : 8'hA5) : 8'($urandom);
            i_m_r_valid = 1'b1; i_m_r_byte = v;
            tick();
            i_m_r_valid = 1'b0;
            rd_exp.push_back(v);
        end
        if (extra) begin
            i_m_r_valid = 1'b1; i_m_r_byte = 8'hEE;
            tick();
            i_m_r_valid = 1'b0;
        end
        tick();
        pulse_done();
        wait_done(d0, 8);
        chk("rd_count", rd_got.size(), L);
        for (int i = 0; i < L && i < rd_got.size(); i++) chk("rd_byte", rd_got[i], rd_exp[i]);
        chk("r_err", o_error, 2'b00);
    endtask

    // a write command must not be taken while the FIFO is empty
    task automatic empty_write_refused();
        int s0;
        s0 = n_start;
        i_cmd_valid = 1'b1; i_cmd_rw = 1'b0; i_cmd_address = 7'h11; i_cmd_len = 8'd1;
        repeat (3) tick();
        i_cmd_valid = 1'b0;
        chk("empty_w_busy", o_busy, 0);
        chk("empty_w_ready", o_cmd_ready, 1);
        chk("empty_w_start", n_start - s0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0, d0, a0, nb;
        tick(); tick();
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_wr_ready", o_wr_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_error", o_error, 0);
        chk("rst_start", o_m_start, 0);
        chk("rst_abort", o_m_abort, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_m_fields", {o_m_rw, o_m_address, o_m_amount_of_bytes, o_m_w_byte, o_rd_byte}, 0);
        i_rst = 1'b0;
        tick();

        empty_write_refused();

        // plain write of three bytes
        push(8'hA1); push(8'hB2); push(8'hC3);
        do_write(7'h3C, 8'd3, 1'b0);
        chk("w1_fifo_empty_ready", o_wr_ready, 1);
        empty_write_refused();

        // read of two bytes, then a read with a surplus byte and len 0
        do_read(7'h50, 8'd2, 1'b0, 1'b1);
        do_read(7'h21, 8'd0, 1'b1, 1'b0);

        // underrun: four requested, two buffered
        push(8'($urandom)); push(8'($urandom));
        do_write(7'h12, 8'd4, 1'b0);
        empty_write_refused();

        // NACK after the first byte flushes the rest
        for (int i = 0; i < 5; i++) push(8'($urandom));
        s0 = n_start; d0 = n_done;
        send_cmd(1'b0, 7'h33, 8'd2);
        wait_start(s0);
        chk("nack_w_byte", o_m_w_byte, fifo_m[0]);
        i_m_byte_req = 1'b1; tick(); i_m_byte_req = 1'b0;
        void'(fifo_m.pop_front());
        gap();
        i_m_nack = 1'b1; tick(); i_m_nack = 1'b0;
        fifo_m.delete();
        chk("nack_err", o_error, 2'b01);
        chk("nack_wr_ready", o_wr_ready, 1);
        gap();
        pulse_done();
        wait_done(d0, 8);
        chk("nack_err_hold", o_error, 2'b01);
        empty_write_refused();

        // NACK together with done ends the transaction straight away
        push(8'h77); push(8'h78);
        s0 = n_start; d0 = n_done;
        send_cmd(1'b0, 7'h34, 8'd2);
        wait_start(s0);
        i_m_nack = 1'b1; i_m_done = 1'b1; tick(); i_m_nack = 1'b0; i_m_done = 1'b0;
        fifo_m.delete();
        wait_done(d0, 2);
        chk("nackdone_err", o_error, 2'b01);
        empty_write_refused();

        // watchdog: silent master, then silent again during stop
        s0 = n_start; d0 = n_done; a0 = n_abort;
        send_cmd(1'b1, 7'h44, 8'd2);
        wait_start(s0);
        for (int i = 0; i < 40 && n_abort == a0; i++) tick();
        chk("tmo_abort", n_abort - a0, 1);
        chk("tmo_abort_at", t_abort - t_start, TMO);
        chk("tmo_err", o_error, 2'b11);
        wait_done(d0, 40);
        chk("tmo_second_window", (t_done - t_abort >= TMO) && (t_done - t_abort <= TMO + 3), 1);
        chk("tmo_single_abort", n_abort - a0, 1);
        chk("tmo_err_hold", o_error, 2'b11);

        // watchdog abort followed by a proper STOP
        s0 = n_start; d0 = n_done; a0 = n_abort;
        send_cmd(1'b1, 7'h45, 8'd1);
        wait_start(s0);
        for (int i = 0; i < 40 && n_abort == a0; i++) tick();
        chk("tmo2_abort_at", t_abort - t_start, TMO);
        tick(); tick();
        pulse_done();
        wait_done(d0, 4);
        chk("tmo2_err", o_error, 2'b11);

        // randomized mix; the byte+done merge covers the counted-first case
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                nb = $urandom_range(0, 4);
                for (int i = 0; i < nb && fifo_m.size() < DEPTH; i++) push(8'($urandom));
                if (fifo_m.size() == 0) push(8'($urandom));
                do_write(7'($urandom), 8'($urandom_range(0, 6)), 1'($urandom));
            end else begin
                do_read(7'($urandom), 8'($urandom_range(0, 4)), 1'($urandom), 1'b0);
            end
        end

        // fill the FIFO, one refused push, then reset mid-transaction
        while (fifo_m.size() < DEPTH) push(8'($urandom));
        chk("full_wr_ready", o_wr_ready, 0);
        push(8'hFF);
        s0 = n_start;
        send_cmd(1'b1, 7'h66, 8'd3);
        wait_start(s0);
        tick();
        #2 i_rst = 1'b1;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_cmd_ready", o_cmd_ready, 1);
        chk("arst_wr_ready", o_wr_ready, 1);
        chk("arst_error", o_error, 0);
        chk("arst_m_fields", {o_m_rw, o_m_address, o_m_amount_of_bytes, o_m_w_byte}, 0);
        tick(); tick();
        i_rst = 1'b0;
        fifo_m.delete();
        tick();
        empty_write_refused();
        push(8'h5C);
        do_write(7'h3C, 8'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
